// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states, default width
// and the bit-counter width helper.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int cnt_width(input int w);
        return ($clog2(w) < 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full subtractor: D = A - B - Bin with borrow-out.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    assign D    = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor D = A - B - Bin, LSB first, one bit per clock.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output OVF.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_d;
    logic [CW-1:0]    r_cnt;
    logic             r_br;
    logic             r_bout;
    logic             r_start_ready;
    logic             r_done_valid;
    logic             w_d;
    logic             w_bout;
    logic             w_last;

    assign w_last = (r_cnt == LAST_CNT);

    full_subtractor u_cell (
        .A    (r_a[0]),
        .B    (r_b[0]),
        .Bin  (r_br),
        .D    (w_d),
        .Bout (w_bout)
    );

    // Next-state decode for the IDLE -> SHIFT -> DONE handshake FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_valid) w_state_nxt = ST_SHIFT;
                else             w_state_nxt = ST_IDLE;
            end
            ST_SHIFT: begin
                if (w_last) w_state_nxt = ST_DONE;
                else        w_state_nxt = ST_SHIFT;
            end
            ST_DONE: begin
                if (done_ready) w_state_nxt = ST_IDLE;
                else            w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, handshake flags and the serial datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_a           <= {WIDTH{1'b0}};
            r_b           <= {WIDTH{1'b0}};
            r_d           <= {WIDTH{1'b0}};
            r_cnt         <= {CW{1'b0}};
            r_br          <= 1'b0;
            r_bout        <= 1'b0;
            r_start_ready <= 1'b1;
            r_done_valid  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_start_ready <= (w_state_nxt == ST_IDLE);
            r_done_valid  <= (w_state_nxt == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (start_valid) begin
                        r_a   <= A;
                        r_b   <= B;
                        r_br  <= Bin;
                        r_cnt <= {CW{1'b0}};
                    end
                end
                ST_SHIFT: begin
                    // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                    r_d  <= {w_d, r_d[WIDTH-1:1]};
                    r_a  <= {1'b0, r_a[WIDTH-1:1]};
                    r_b  <= {1'b0, r_b[WIDTH-1:1]};
                    r_br <= w_bout;
                    if (w_last) begin
                        r_cnt  <= {CW{1'b0}};
                        r_bout <= w_bout;
                    end else begin
                        r_cnt  <= r_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign start_ready = r_start_ready;
    assign done_valid  = r_done_valid;
    assign D           = r_d;
    assign Bout        = r_bout;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    // Operand signs captured at load; overflow resolves together with the sign bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if ((r_state == ST_IDLE) && start_valid) begin
            r_a_msb <= A[WIDTH-1];
            r_b_msb <= B[WIDTH-1];
        end else if ((r_state == ST_SHIFT) && w_last) begin
            r_ovf   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
        end
    end

    assign OVF = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         bin_in;
    logic         done_valid;
    logic         done_ready;
    logic [W-1:0] d_out;
    logic         bout_out;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         ovf_out;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .A           (a_in),
        .B           (b_in),
        .Bin         (bin_in),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .D           (d_out),
        .Bout        (bout_out)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .OVF         (ovf_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bout;
        logic       ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Starts an op from IDLE and waits (bounded) for done_valid; leaves DUT in DONE.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          output int lat);
        chk("ready_before_start", 32'(start_ready), 32'd1);
        a_in = a; b_in = b; bin_in = bin; start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        a_in = 8'h00; b_in = 8'h00; bin_in = 1'b0;
        lat = 0;
        while (!done_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic finish_op();
        done_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        done_ready = 1'b0;
        chk("done_valid_after_handshake", 32'(done_valid), 32'd0);
        chk("start_ready_after_handshake", 32'(start_ready), 32'd1);
    endtask

    task automatic chk_result(input string tag, input logic [7:0] d, input logic bo, input logic ov);
        chk({tag, "_D"}, 32'(d_out), 32'(d));
        chk({tag, "_Bout"}, 32'(bout_out), 32'(bo));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk({tag, "_OVF"}, 32'(ovf_out), 32'(ov));
`else
        if (ov === 1'bx) $display("unexpected X in expected OVF for %s", tag);
`endif
    endtask

    initial begin
        int lat;
        int cnt;
        int got;
        int prev_cyc;
        logic [16:0] q[$];
        logic [16:0] e;
        logic [8:0]  t;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{8'h10, 8'h20, 1'b1, 8'hEF, 1'b1, 1'b0};
        vecs[7] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1};
        vecs[8] = '{8'h3C, 8'h3C, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[9] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};

        rst_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0;
        a_in = 8'h00; b_in = 8'h00; bin_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_result("reset", 8'h00, 1'b0, 1'b0);
        chk("reset_done_valid", 32'(done_valid), 32'd0);
        chk("reset_start_ready", 32'(start_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
            chk_result($sformatf("vec%0d", i), vecs[i].d, vecs[i].bout, vecs[i].ovf);
            finish_op();
        end

        // Backpressure: DONE held 5 cycles, start pulses must be ignored.
        run_op(8'h80, 8'h01, 1'b0, lat);
        for (int c = 0; c < 5; c++) begin
            start_valid = c[0];
            a_in = 8'h11; b_in = 8'h22;
            @(posedge clk);
            @(negedge clk);
            chk_result($sformatf("bp%0d", c), 8'h7F, 1'b0, 1'b1);
            chk($sformatf("bp%0d_done_valid", c), 32'(done_valid), 32'd1);
            chk($sformatf("bp%0d_start_ready", c), 32'(start_ready), 32'd0);
        end
        start_valid = 1'b0;
        finish_op();
        chk_result("bp_after", 8'h7F, 1'b0, 1'b1);

        // Reset after 3 SHIFT edges aborts the op.
        a_in = 8'h33; b_in = 8'h11; start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_result("rst_shift", 8'h00, 1'b0, 1'b0);
        chk("rst_shift_done_valid", 32'(done_valid), 32'd0);
        chk("rst_shift_start_ready", 32'(start_ready), 32'd1);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_valid) cnt++;
        end
        chk("rst_no_spurious_done", 32'(cnt), 32'd0);
        run_op(8'hFF, 8'hFF, 1'b0, lat);
        chk("post_rst_latency", 32'(lat), 32'd8);
        chk_result("post_rst", 8'h00, 1'b0, 1'b0);

        // Reset while waiting in DONE.
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_done_done_valid", 32'(done_valid), 32'd0);
        chk("rst_done_start_ready", 32'(start_ready), 32'd1);
        rst_n = 1'b1;
        run_op(8'h05, 8'h03, 1'b0, lat);
        chk_result("post_rst2", 8'h02, 1'b0, 1'b0);
        finish_op();

        // Back-to-back with done_ready and start_valid tied high.
        done_ready = 1'b1;
        start_valid = 1'b1;
        got = 0;
        prev_cyc = -1;
        for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
            if (done_valid) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    t = {1'b0, e[16:9]} - {1'b0, e[8:1]} - {8'h00, e[0]};
                    chk_result($sformatf("b2b%0d", got), t[7:0], t[8],
                               (e[16] != e[8]) && (t[7] != e[16]));
                end else begin
                    chk("b2b_unexpected_result", 32'd1, 32'd0);
                end
                if (prev_cyc >= 0) chk($sformatf("b2b%0d_interval", got), 32'(cyc - prev_cyc), 32'd10);
                prev_cyc = cyc;
                got++;
            end
            if (start_ready) begin
                a_in = 8'($urandom);
                b_in = 8'($urandom);
                bin_in = 1'($urandom_range(0, 1));
                q.push_back({a_in, b_in, bin_in});
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk("b2b_result_count", 32'(got), 32'd8);
        start_valid = 1'b0;
        done_ready = 1'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
